// File: rtl/posit_prod_pkg.sv
// Shared width helpers for the raw posit product adder. The field layouts are
// parameter-dependent, so the struct typedefs live next to their parameters.
package posit_prod_pkg;

    function automatic int in_w(input int scale_w, input int frac_w);
        return scale_w + frac_w + 3;
    endfunction

    function automatic int of_w(input int frac_w, input int guard);
        return frac_w + guard;
    endfunction

    function automatic int out_w(input int scale_w, input int frac_w, input int guard);
        return scale_w + frac_w + guard + 3;
    endfunction

endpackage

// File: rtl/posit_pipe_ctrl.sv
// Stage-valid shift register, global advance / in_ready, and the saturating
// truncation event counter for the four-stage product adder.
module posit_pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             out_ready,
    input  logic             truncated,
    output logic             adv,
    output logic             in_ready,
    output logic [3:0]       stage_v,
    output logic [CNT_W-1:0] trunc_cnt
);

    // Handshake: a transfer happens on a clock edge where valid & ready are both 1;
    // the whole pipe moves together only when the output slot is empty or taken.
    assign adv      = ~stage_v[3] | out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_v   <= '0;
            trunc_cnt <= '0;
        end else begin
            if (adv) begin
                stage_v[3:1] <= stage_v[2:0];
                // An unknown in_valid falls through to the else branch and is ignored.
                if (in_valid) stage_v[0] <= 1'b1;
                else          stage_v[0] <= 1'b0;
            end
            if (stage_v[3] && out_ready && truncated && trunc_cnt != '1)
                trunc_cnt <= trunc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/positadd_prod_raw_pipe.sv
// Four-stage adder of two serialized raw posit products producing an unrounded
// sum {sgn, scale, fraction, inf, zero} plus a flag for discarded nonzero bits.
module positadd_prod_raw_pipe
    import posit_prod_pkg::*;
#(
    parameter  int SCALE_W = 10,
    parameter  int FRAC_W  = 54,
    parameter  int GUARD   = 3,
    parameter  int CNT_W   = 16,
    localparam int IN_W    = in_w(SCALE_W, FRAC_W),
    localparam int OFW     = of_w(FRAC_W, GUARD),
    localparam int OUT_W   = out_w(SCALE_W, FRAC_W, GUARD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in1,
    input  logic [IN_W-1:0]  in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             truncated,
    output logic [CNT_W-1:0] trunc_cnt
);

    localparam int MW  = FRAC_W + GUARD + 1;
    localparam int RW  = MW + 1;
    localparam int LZW = $clog2(RW + 1);
    localparam logic [SCALE_W+1:0] SC_MAX = (SCALE_W+2)'((1 << (SCALE_W - 1)) - 1);
    localparam logic [SCALE_W+1:0] SC_MIN = (SCALE_W+2)'(-(1 << (SCALE_W - 1)));

    typedef struct packed {
        logic               sgn;
        logic [SCALE_W-1:0] scale;
        logic [FRAC_W-1:0]  frac;
        logic               inf;
        logic               zero;
    } value_prod_t;

    typedef struct packed {
        logic               sgn;
        logic [SCALE_W-1:0] scale;
        logic [OFW-1:0]     frac;
        logic               inf;
        logic               zero;
    } value_prod_sum_t;

    logic       adv;
    logic [3:0] stage_v;

    posit_pipe_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .truncated (truncated),
        .adv       (adv),
        .in_ready  (in_ready),
        .stage_v   (stage_v),
        .trunc_cnt (trunc_cnt)
    );
    assign out_valid = stage_v[3];

    // S1: flush zero operands, pick the larger magnitude as hi.
    value_prod_t        a, b, hi_c, lo_c;
    logic               a_wins;
    logic [SCALE_W:0]   d_c;
    always_comb begin
        a = in1;
        b = in2;
        if (a.zero) begin a = '0; a.zero = 1'b1; end
        if (b.zero) begin b = '0; b.zero = 1'b1; end
        if (a.zero)                    a_wins = 1'b0;
        else if (b.zero)               a_wins = 1'b1;
        else if (a.scale != b.scale)   a_wins = $signed(a.scale) > $signed(b.scale);
        else                           a_wins = a.frac >= b.frac;
        hi_c = a_wins ? a : b;
        lo_c = a_wins ? b : a;
        d_c  = {hi_c.scale[SCALE_W-1], hi_c.scale} - {lo_c.scale[SCALE_W-1], lo_c.scale};
    end

    logic [MW-1:0]      s1_hi_m, s1_lo_m;
    logic [SCALE_W-1:0] s1_scale;
    logic [SCALE_W:0]   s1_d;
    logic               s1_sgn, s1_op, s1_inf;
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_hi_m  <= {~hi_c.zero, hi_c.frac, {GUARD{1'b0}}};
            s1_lo_m  <= {~lo_c.zero, lo_c.frac, {GUARD{1'b0}}};
            s1_scale <= hi_c.scale;
            s1_sgn   <= hi_c.sgn;
            s1_op    <= ~(a.sgn ^ b.sgn);
            s1_d     <= d_c;
            s1_inf   <= in1[1] | in2[1];
        end
    end

    // S2: align lo; everything shifted out of the mantissa folds into sticky.
    logic [MW-1:0] lo_al, lost_mask;
    logic [RW-1:0] raw_c;
    logic          sticky_c;
    always_comb begin
        lost_mask = '0;
        if (32'(s1_d) >= 32'(MW)) begin
            lo_al    = '0;
            sticky_c = |s1_lo_m;
        end else begin
            lo_al     = s1_lo_m >> s1_d;
            lost_mask = ~({MW{1'b1}} << s1_d);
            sticky_c  = |(s1_lo_m & lost_mask);
        end
        raw_c = s1_op ? ({1'b0, s1_hi_m} + {1'b0, lo_al})
                      : ({1'b0, s1_hi_m} - {1'b0, lo_al});
    end

    logic [RW-1:0]      s2_raw;
    logic [SCALE_W-1:0] s2_scale;
    logic               s2_sgn, s2_inf, s2_sticky;
    always_ff @(posedge clk) begin
        if (adv && stage_v[0]) begin
            s2_raw    <= raw_c;
            s2_sticky <= sticky_c;
            s2_scale  <= s1_scale;
            s2_sgn    <= s1_sgn;
            s2_inf    <= s1_inf;
        end
    end

    // S3: leading-zero count and the provisional (unsaturated) scale.
    logic [LZW-1:0]     lz_c;
    logic               found;
    logic [SCALE_W+1:0] sc_c;
    always_comb begin
        lz_c  = LZW'(RW);
        found = 1'b0;
        for (int i = RW - 1; i >= 0; i--) begin
            if (!found && s2_raw[i]) begin
                lz_c  = LZW'(RW - 1 - i);
                found = 1'b1;
            end
        end
        sc_c = {{2{s2_scale[SCALE_W-1]}}, s2_scale} + (SCALE_W+2)'(1) - (SCALE_W+2)'(lz_c);
    end

    logic [RW-1:0]      s3_raw;
    logic [LZW-1:0]     s3_lz;
    logic [SCALE_W+1:0] s3_scale;
    logic               s3_sgn, s3_inf, s3_sticky;
    always_ff @(posedge clk) begin
        if (adv && stage_v[1]) begin
            s3_raw    <= s2_raw;
            s3_lz     <= lz_c;
            s3_scale  <= sc_c;
            s3_sticky <= s2_sticky;
            s3_sgn    <= s2_sgn;
            s3_inf    <= s2_inf;
        end
    end

    // S4: drop the leading one, keep the top OFW bits, saturate the scale.
    logic [RW-1:0]   norm_c;
    value_prod_sum_t res_c;
    logic            trunc_c;
    always_comb begin
        norm_c  = s3_raw << (32'(s3_lz) + 32'd1);
        res_c   = '0;
        trunc_c = 1'b0;
        if (s3_inf) begin
            res_c.inf = 1'b1;
        end else if (s3_raw == '0) begin
            res_c.zero = 1'b1;
        end else begin
            res_c.sgn  = s3_sgn;
            res_c.frac = norm_c[RW-1 -: OFW];
            trunc_c    = s3_sticky | (s3_raw[RW-1] & s3_raw[0]);
            if ($signed(s3_scale) > $signed(SC_MAX)) begin
                res_c.scale = SC_MAX[SCALE_W-1:0];
                trunc_c     = 1'b1;
            end else if ($signed(s3_scale) < $signed(SC_MIN)) begin
                res_c.scale = SC_MIN[SCALE_W-1:0];
                trunc_c     = 1'b1;
            end else begin
                res_c.scale = s3_scale[SCALE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            truncated <= 1'b0;
        end else if (adv && stage_v[2]) begin
            result    <= res_c;
            truncated <= trunc_c;
        end
    end

endmodule

// File: tb/tb_positadd_prod_raw_pipe.sv
// Bench for positadd_prod_raw_pipe: vector table through a scoreboard plus
// latency, counter, back-pressure and mid-stream reset sequences.
module tb_positadd_prod_raw_pipe;

    localparam int SW = 10, FW = 54, G = 3, CW = 16;
    localparam int IW = SW + FW + 3, OFW = FW + G, OW = SW + OFW + 3;

    localparam logic [FW-1:0]  F_HALF = {1'b1, 53'b0};
    localparam logic [FW-1:0]  F_QTR  = {2'b01, 52'b0};
    localparam logic [FW-1:0]  F_LSB  = 54'd1;
    localparam logic [FW-1:0]  F_ALL  = '1;
    localparam logic [OFW-1:0] O_MSB  = {1'b1, 56'b0};
    localparam logic [OFW-1:0] O_2P53 = {4'b0001, 53'b0};
    localparam logic [OFW-1:0] O_V6   = {4'b0001, 53'b0} - 57'd4;

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic          in_ready, out_valid, truncated;
    logic [IW-1:0] in1 = '0, in2 = '0;
    logic [OW-1:0] result;
    logic [CW-1:0] trunc_cnt;

    positadd_prod_raw_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .truncated (truncated),
        .trunc_cnt (trunc_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, rcv = 0;
    logic [OW:0] exp_q[$];
    logic [OW:0] cur_exp = '0;

    typedef struct {
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        logic [OW-1:0] res;
        logic          trunc;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [IW-1:0] mk_in(input logic s, input int sc, input logic [FW-1:0] f,
                                            input logic inf, input logic z);
        logic [SW-1:0] scv;
        scv = SW'(sc);
        return {s, scv, f, inf, z};
    endfunction

    function automatic logic [OW-1:0] mk_out(input logic s, input int sc, input logic [OFW-1:0] f,
                                             input logic inf, input logic z);
        logic [SW-1:0] scv;
        scv = SW'(sc);
        return {s, scv, f, inf, z};
    endfunction

    task automatic check(input string name, input logic [OW:0] got, input logic [OW:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Scoreboard: push on accepted input, pop on accepted output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
            if (out_valid && out_ready) begin
                rcv++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got=%h", {result, truncated});
                end else begin
                    check("scoreboard", {result, truncated}, exp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [IW-1:0] a, input logic [IW-1:0] b,
                        input logic [OW-1:0] r, input logic t);
        int   n   = 0;
        logic acc = 1'b0;
        in1 = a; in2 = b; cur_exp = {r, t}; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("send_accept", {{OW{1'b0}}, acc}, {{OW{1'b0}}, 1'b1});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", (OW+1)'(exp_q.size()), '0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_timed(input string name, input logic [IW-1:0] a, input logic [IW-1:0] b,
                              input logic [OW-1:0] r, input logic t);
        int lat = 1;
        send(a, b, r, t);
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, (OW+1)'(lat), (OW+1)'(4));
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;
        int rcv0;
        logic [IW-1:0] zero_in;
        zero_in = mk_in(1'b0, 0, '0, 1'b0, 1'b1);

        tbl[0]  = '{mk_in(0, 0, '0, 0, 0),      mk_in(1, 0, '0, 0, 0),     mk_out(0, 0, '0, 0, 1), 1'b0};
        tbl[1]  = '{mk_in(0, 0, '0, 1, 0),      mk_in(1, 5, 54'd123, 0, 0), mk_out(0, 0, '0, 1, 0), 1'b0};
        tbl[2]  = '{mk_in(0, 0, F_HALF, 0, 0),  mk_in(0, 0, F_HALF, 0, 0), mk_out(0, 1, O_MSB, 0, 0), 1'b0};
        tbl[3]  = '{mk_in(0, 0, F_ALL, 0, 0),   mk_in(0, -3, F_LSB, 0, 0), mk_out(0, 1, O_V6, 0, 0), 1'b1};
        tbl[4]  = '{mk_in(0, 511, '0, 0, 0),    mk_in(0, 511, '0, 0, 0),   mk_out(0, 511, '0, 0, 0), 1'b1};
        tbl[5]  = '{mk_in(0, -512, F_LSB, 0, 0), mk_in(1, -512, '0, 0, 0), mk_out(0, -512, '0, 0, 0), 1'b1};
        tbl[6]  = '{mk_in(1, 7, 54'd5, 0, 1),   mk_in(1, -2, F_QTR, 0, 0), mk_out(1, -2, {F_QTR, 3'b000}, 0, 0), 1'b0};
        tbl[7]  = '{mk_in(0, 0, '0, 0, 1),      mk_in(1, 3, 54'd5, 0, 1),  mk_out(0, 0, '0, 0, 1), 1'b0};
        tbl[8]  = '{mk_in(0, 0, '0, 0, 0),      mk_in(1, 1, '0, 0, 0),     mk_out(1, 0, '0, 0, 0), 1'b0};
        tbl[9]  = '{mk_in(0, 4, '0, 0, 0),      mk_in(0, 0, F_LSB, 0, 0),  mk_out(0, 4, O_2P53, 0, 0), 1'b1};
        tbl[10] = '{mk_in(1, 0, '0, 0, 0),      mk_in(0, 0, F_HALF, 0, 0), mk_out(0, -1, '0, 0, 0), 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", (OW+1)'(out_valid), '0);
        check("reset_in_ready", (OW+1)'(in_ready), (OW+1)'(1));
        check("reset_result", {result, truncated}, '0);
        check("reset_cnt", (OW+1)'(trunc_cnt), '0);
        @(posedge clk);
        #1;

        // 1.0 + 1.0 with latency
        send_timed("latency_1p1", mk_in(0, 0, '0, 0, 0), mk_in(0, 0, '0, 0, 0), mk_out(0, 1, '0, 0, 0), 1'b0);

        // Alignment loss: counter 0 -> 1
        check("cnt_before_loss", (OW+1)'(trunc_cnt), '0);
        send(mk_in(0, 0, F_HALF, 0, 0), mk_in(0, -60, F_LSB, 0, 0), mk_out(0, 0, {F_HALF, 3'b000}, 0, 0), 1'b1);
        drain();
        check("cnt_after_loss", (OW+1)'(trunc_cnt), (OW+1)'(1));

        // Vector table, streamed back to back
        exp_cnt = 1;
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].trunc);
            exp_cnt += int'(tbl[i].trunc);
        end
        drain();
        check("cnt_after_table", (OW+1)'(trunc_cnt), (OW+1)'(exp_cnt));

        // Back-pressure: out_ready low during cycles 5..7 of an 8-pair burst
        rcv0 = rcv;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send(mk_in(0, k, '0, 0, 0), zero_in, mk_out(0, k, '0, 0, 0), 1'b0);
            end
            begin
                for (int c = 0; c < 13; c++) begin
                    out_ready = !(c >= 5 && c <= 7);
                    @(negedge clk);
                    check($sformatf("bp_in_ready_c%0d", c), (OW+1)'(in_ready),
                          (OW+1)'(!(c >= 5 && c <= 7)));
                    if (c >= 5 && c <= 7)
                        check($sformatf("bp_stable_c%0d", c), {result, truncated},
                              {mk_out(0, 1, '0, 0, 0), 1'b0});
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_result_count", (OW+1)'(rcv - rcv0), (OW+1)'(8));

        // Reset with three operations in flight
        for (int k = 0; k < 3; k++)
            send(mk_in(0, 2, '0, 0, 0), mk_in(0, 2, '0, 0, 0), mk_out(0, 3, '0, 0, 0), 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", (OW+1)'(out_valid), '0);
        check("midrst_cnt", (OW+1)'(trunc_cnt), '0);
        @(posedge clk);
        #1;
        rcv0 = rcv;
        send_timed("latency_after_rst", mk_in(0, 0, F_HALF, 0, 0), mk_in(0, 0, F_HALF, 0, 0),
                   mk_out(0, 1, O_MSB, 0, 0), 1'b0);
        check("after_rst_count", (OW+1)'(rcv - rcv0), (OW+1)'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
